sat_blend: RTL and testbench
============================

# sat_blend

Pixel-stream blender that sits directly downstream of the saturation stage. It takes that stage's aligned RGB565 pair, the unmodified pixel (raw) and the saturation-enhanced pixel (dst), plus the DE/VS syncs, and produces one RGB565 output stream. The output is a per-channel alpha blend of the two inputs, a left/right split-screen comparison, or a bypass of either input. Configuration is shadowed per frame so the output never changes mode mid-frame.

## Interface
Parameters:
- `MAX_COL`, 4095: column-counter saturation value; also the width of `cfg_split_x`, which is 12 bits.

Ports:
- `clk`  in  1  pixel clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `raw_data`  in  16  RGB565 unprocessed pixel.
- `dst_data`  in  16  RGB565 saturation-enhanced pixel, same cycle as `raw_data`.
- `in_de`  in  1  data enable, active high.
- `in_vs`  in  1  vertical sync, active high.
- `cfg_mode`  in  2  0 = blend, 1 = split, 2 = raw bypass, 3 = dst bypass.
- `cfg_alpha`  in  5  dst weight, 0..16; values above 16 clamp to 16.
- `cfg_split_x`  in  12  first column that shows dst in split mode.
- `blend_data`  out  16  RGB565 result.
- `blend_de`  out  1  `in_de` delayed by 3 cycles.
- `blend_vs`  out  1  `in_vs` delayed by 3 cycles.
- `line_cnt`  out  12  completed active lines in the current frame.

## Operation
- **Frame shadowing**
  - On a rising edge of `in_vs` (previous-cycle `in_vs`=0, current=1), latch `cfg_mode`, the clamped `cfg_alpha`, and `cfg_split_x` into shadow registers. In the same cycle, clear `line_cnt`.
  - Only shadow values drive the datapath. Config changes mid-frame take effect at the next VS rising edge.
  - Reset values of the shadows: mode 0, alpha 0, split_x 0. Until the first VS edge, the output therefore equals raw.
- **Column counter `col`**
  - 0 whenever `in_de`=0.
  - Increments by 1 on each cycle with `in_de`=1.
  - Saturates at `MAX_COL`; it does not wrap.
  - The pixel in a cycle is at column `col`, so the first pixel of a line is column 0.
- **Line counter**
  - `line_cnt` increments on each `in_de` falling edge.
  - Saturates at 4095.
  - Cleared by VS rising edge and by reset.
- **Expansion**: each channel is zero-padded to 8 bits: R = {r5,3'b0}, G = {g6,2'b0}, B = {b5,3'b0}.
- **Blend (mode 0)**
  - Per channel: out8 = (raw8·(16−α) + dst8·α) >> 4.
  - The product sum is 12 bits and never exceeds 4080.
  - Truncate, never round.
- **Split (mode 1)**: select raw when `col` < split_x, otherwise dst.
- **Bypass (mode 2/3)**: select raw (mode 2) or dst (mode 3).
- **Packing**: {R8[7:3], G8[7:2], B8[7:3]}.
- **Blanking**: `blend_data` is forced to 16'h0000 whenever `blend_de`=0.
- **Exactness**:
  - α=0, or mode 2, reproduces `raw_data` bit-exactly.
  - α=16, or mode 3, reproduces `dst_data` bit-exactly.

## Timing
- **Pipeline**: fixed 3 cycles from input to output for data, DE, and VS alike.
  - Stage 1: register inputs, the mode/select decision, and the expanded channels.
  - Stage 2: multiply and sum.
  - Stage 3: shift, pack, and apply the blanking mask.
- No stalls and no backpressure. One pixel is accepted every cycle.
- **Shadow update timing**: the update takes effect for the pixel that arrives in the cycle after the VS rising edge.
- **Reset** (`rst_n`=0 at a clock edge):
  - Next cycle: all pipeline registers, `col`, `line_cnt`, and the shadows return to reset values.
  - `blend_data`=0, `blend_de`=0, `blend_vs`=0, `line_cnt`=0.
- **Reset mid-line**: the partial line is dropped. Output resumes with 3-cycle latency after `rst_n` returns to 1.
- **Split boundaries**: split_x=0 gives all dst; split_x above line width gives all raw.
- **Simultaneous `in_vs` rise and `in_de`=1**: the shadow is still latched. That pixel uses the old shadow.

## Test plan
- **Reset**: hold `rst_n`=0 for 4 cycles with random inputs -> `blend_data`=0, `blend_de`=0, `blend_vs`=0, `line_cnt`=0; after release with mode bits floating but no VS edge, output equals raw.
- **Blend midpoint**: α=8, mode 0, latched by a VS pulse, raw=16'hF800, dst=16'h001F -> `blend_data`=16'h780F exactly 3 cycles after input, with `blend_de` aligned.
- **Endpoints and clamp**: α=0 -> output equals raw bit-exactly over 1000 random pixels; α=16 and α=31 (clamped) -> output equals dst bit-exactly.
- **Split**: mode 1, split_x=5, 10-pixel line with raw=16'hFFFF and dst=16'h0000 -> columns 0..4 give 16'hFFFF, columns 5..9 give 16'h0000; repeated lines restart at column 0.
- **Shadowing**: change cfg_mode from 2 to 3 mid-frame -> output stays raw until the pixel after the next `in_vs` rising edge, then becomes dst; after 3 lines, `line_cnt`=3, and it clears at VS.
- **Mid-line reset**: assert `rst_n`=0 for 1 cycle in the middle of a line -> outputs are 0 the next cycle; after release, a new line's pixels start at column 0 with 3-cycle latency.

Source files
------------

// File: rtl/sat_blend.sv
// RGB565 blender after the saturation stage: alpha blend, split-screen or bypass of raw/dst.
// Configuration is captured on each VS rising edge; the datapath is a fixed 3-stage pipeline.
module sat_blend #(
   parameter int MAX_COL = 4095
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] raw_data,
   input  logic [15:0] dst_data,
   input  logic        in_de,
   input  logic        in_vs,
   input  logic [1:0]  cfg_mode,
   input  logic [4:0]  cfg_alpha,
   input  logic [11:0] cfg_split_x,
   output logic [15:0] blend_data,
   output logic        blend_de,
   output logic        blend_vs,
   output logic [11:0] line_cnt
);

   localparam logic [11:0] COL_LIMIT  = 12'(MAX_COL);
   localparam logic [11:0] LINE_LIMIT = 12'd4095;
   localparam logic [4:0]  ALPHA_FULL = 5'd16;

   // Frame-level control: edge detectors, shadows, column and line counters
   logic        vs_prev_reg;
   logic        de_prev_reg;
   logic        vs_rise;
   logic        de_fall;
   logic [1:0]  mode_reg;
   logic [4:0]  alpha_reg;
   logic [11:0] split_x_reg;
   logic [11:0] col_reg;
   logic [11:0] col_next;
   logic [11:0] line_cnt_reg;
   logic [11:0] line_cnt_next;
   logic [4:0]  alpha_clamped;
   logic [4:0]  weight_next;

   assign vs_rise       = in_vs & ~vs_prev_reg;
   assign de_fall       = de_prev_reg & ~in_de;
   assign alpha_clamped = (cfg_alpha > ALPHA_FULL) ? ALPHA_FULL : cfg_alpha;

   always_comb begin
      col_next = 12'd0;
      if (in_de) begin
         col_next = (col_reg == COL_LIMIT) ? col_reg : col_reg + 12'd1;
      end
   end

   always_comb begin
      line_cnt_next = line_cnt_reg;
      if (vs_rise) begin
         line_cnt_next = 12'd0;
      end else if (de_fall && (line_cnt_reg != LINE_LIMIT)) begin
         line_cnt_next = line_cnt_reg + 12'd1;
      end
   end

   // Every mode reduces to a dst weight: split and bypass use 0 or 16, which are exact.
   always_comb begin
      weight_next = 5'd0;
      case (mode_reg)
         2'd0:    weight_next = alpha_reg;
         2'd1:    weight_next = (col_reg < split_x_reg) ? 5'd0 : ALPHA_FULL;
         2'd2:    weight_next = 5'd0;
         default: weight_next = ALPHA_FULL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vs_prev_reg  <= 1'b0;
         de_prev_reg  <= 1'b0;
         col_reg      <= 12'd0;
         line_cnt_reg <= 12'd0;
         mode_reg     <= 2'd0;
         alpha_reg    <= 5'd0;
         split_x_reg  <= 12'd0;
      end else begin
         vs_prev_reg  <= in_vs;
         de_prev_reg  <= in_de;
         col_reg      <= col_next;
         line_cnt_reg <= line_cnt_next;
         if (vs_rise) begin
            mode_reg    <= cfg_mode;
            alpha_reg   <= alpha_clamped;
            split_x_reg <= cfg_split_x;
         end
      end
   end

   assign line_cnt = line_cnt_reg;

   // Stage 1: expanded channels packed as {R8, G8, B8}, plus weight and syncs
   logic [23:0] s1_raw_reg;
   logic [23:0] s1_dst_reg;
   logic [4:0]  s1_weight_reg;
   logic        s1_de_reg;
   logic        s1_vs_reg;
   logic [4:0]  s1_inv_weight;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_raw_reg    <= 24'd0;
         s1_dst_reg    <= 24'd0;
         s1_weight_reg <= 5'd0;
         s1_de_reg     <= 1'b0;
         s1_vs_reg     <= 1'b0;
      end else begin
         s1_raw_reg    <= {raw_data[15:11], 3'b000, raw_data[10:5], 2'b00, raw_data[4:0], 3'b000};
         s1_dst_reg    <= {dst_data[15:11], 3'b000, dst_data[10:5], 2'b00, dst_data[4:0], 3'b000};
         s1_weight_reg <= weight_next;
         s1_de_reg     <= in_de;
         s1_vs_reg     <= in_vs;
      end
   end

   assign s1_inv_weight = ALPHA_FULL - s1_weight_reg;

   // Stage 2 per channel: weighted sum fits 12 bits (max 255*16); stage 3 keeps bits [11:4]
   logic [7:0] chan_out [3];

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_chan
         logic [11:0] prod_raw;
         logic [11:0] prod_dst;
         logic [11:0] sum_reg;
         logic [3:0]  unused_frac;

         assign prod_raw = {4'd0, s1_raw_reg[8*gi +: 8]} * {7'd0, s1_inv_weight};
         assign prod_dst = {4'd0, s1_dst_reg[8*gi +: 8]} * {7'd0, s1_weight_reg};

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               sum_reg <= 12'd0;
            end else begin
               sum_reg <= prod_raw + prod_dst;
            end
         end

         assign chan_out[gi] = sum_reg[11:4];
         assign unused_frac  = sum_reg[3:0];
      end
   endgenerate

   logic s2_de_reg;
   logic s2_vs_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s2_de_reg <= 1'b0;
         s2_vs_reg <= 1'b0;
      end else begin
         s2_de_reg <= s1_de_reg;
         s2_vs_reg <= s1_vs_reg;
      end
   end

   // Stage 3: pack back to RGB565 and blank outside active video
   logic [15:0] data_reg;
   logic        de_reg;
   logic        vs_reg;
   logic [15:0] packed_next;
   logic [7:0]  unused_pack;

   assign packed_next = {chan_out[2][7:3], chan_out[1][7:2], chan_out[0][7:3]};
   assign unused_pack = {chan_out[2][2:0], chan_out[1][1:0], chan_out[0][2:0]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_reg <= 16'd0;
         de_reg   <= 1'b0;
         vs_reg   <= 1'b0;
      end else begin
         data_reg <= s2_de_reg ? packed_next : 16'd0;
         de_reg   <= s2_de_reg;
         vs_reg   <= s2_vs_reg;
      end
   end

   assign blend_data = data_reg;
   assign blend_de   = de_reg;
   assign blend_vs   = vs_reg;

endmodule

// File: tb/tb_sat_blend.sv
// Randomized bench for sat_blend: a behavioural frame/pixel model is checked every cycle,
// with literal expectations pinning midpoint, endpoints, split columns, shadowing and line count.
module tb_sat_blend;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] raw_data;
   logic [15:0] dst_data;
   logic        in_de;
   logic        in_vs;
   logic [1:0]  cfg_mode;
   logic [4:0]  cfg_alpha;
   logic [11:0] cfg_split_x;
   logic [15:0] blend_data;
   logic        blend_de;
   logic        blend_vs;
   logic [11:0] line_cnt;

   always #5 clk = ~clk;

   sat_blend #(.MAX_COL(4095)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .raw_data    (raw_data),
      .dst_data    (dst_data),
      .in_de       (in_de),
      .in_vs       (in_vs),
      .cfg_mode    (cfg_mode),
      .cfg_alpha   (cfg_alpha),
      .cfg_split_x (cfg_split_x),
      .blend_data  (blend_data),
      .blend_de    (blend_de),
      .blend_vs    (blend_vs),
      .line_cnt    (line_cnt)
   );

   int vectors     = 0;
   int miscompares = 0;
   int cyc_cnt     = 0;

   typedef struct {
      int          cyc;
      logic [15:0] val;
   } lit_t;
   lit_t lit_q[$];

   function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s cyc %0d: got %h expected %h", name, cyc_cnt, act, exp);
      end
   endfunction

   // Reference blend from the arithmetic rule on zero-padded 8-bit channels
   function automatic logic [15:0] mix(input logic [15:0] r, input logic [15:0] d, input int a);
      int         rc[3];
      int         dc[3];
      logic [7:0] o[3];
      rc[0] = int'(r[15:11]) * 8; rc[1] = int'(r[10:5]) * 4; rc[2] = int'(r[4:0]) * 8;
      dc[0] = int'(d[15:11]) * 8; dc[1] = int'(d[10:5]) * 4; dc[2] = int'(d[4:0]) * 8;
      for (int i = 0; i < 3; i++) o[i] = 8'((rc[i] * (16 - a) + dc[i] * a) / 16);
      return {o[0][7:3], o[1][7:2], o[2][7:3]};
   endfunction

   // Behavioural model: frame state plus the three most recent results in flight
   int          m_mode, m_alpha, m_split, m_col, m_line;
   bit          m_vs_prev, m_de_prev;
   logic [15:0] p_data[3];
   logic        p_de[3];
   logic        p_vs[3];

   always @(posedge clk) begin
      logic [15:0] e;
      cyc_cnt++;
      if (!rst_n) begin
         m_mode = 0; m_alpha = 0; m_split = 0; m_col = 0; m_line = 0;
         m_vs_prev = 0; m_de_prev = 0;
         for (int i = 0; i < 3; i++) begin p_data[i] = 0; p_de[i] = 0; p_vs[i] = 0; end
      end else begin
         if (!in_de)            e = 16'h0000;
         else if (m_mode == 0)  e = mix(raw_data, dst_data, m_alpha);
         else if (m_mode == 1)  e = (m_col < m_split) ? raw_data : dst_data;
         else if (m_mode == 2)  e = raw_data;
         else                   e = dst_data;
         p_data[2] = p_data[1]; p_data[1] = p_data[0]; p_data[0] = e;
         p_de[2] = p_de[1]; p_de[1] = p_de[0]; p_de[0] = in_de;
         p_vs[2] = p_vs[1]; p_vs[1] = p_vs[0]; p_vs[0] = in_vs;
         if (in_vs && !m_vs_prev) begin
            m_mode  = int'(cfg_mode);
            m_alpha = (cfg_alpha > 5'd16) ? 16 : int'(cfg_alpha);
            m_split = int'(cfg_split_x);
            m_line  = 0;
         end else if (m_de_prev && !in_de && m_line < 4095) begin
            m_line++;
         end
         m_col = in_de ? ((m_col < 4095) ? m_col + 1 : 4095) : 0;
         m_vs_prev = in_vs;
         m_de_prev = in_de;
      end
   end

   always @(negedge clk) begin
      if (cyc_cnt >= 1) begin
         chk("data", blend_data, p_data[2]);
         chk("de", 16'(blend_de), 16'(p_de[2]));
         chk("vs", 16'(blend_vs), 16'(p_vs[2]));
         chk("line_cnt", 16'(line_cnt), 16'(m_line));
         while (lit_q.size() > 0 && lit_q[0].cyc <= cyc_cnt) begin
            chk("literal_data", blend_data, lit_q[0].val);
            chk("literal_de", 16'(blend_de), 16'd1);
            void'(lit_q.pop_front());
         end
      end
   end

   task automatic px(input bit rst, input logic [15:0] r, input logic [15:0] d,
                     input logic de, input logic vs, input bit lit, input logic [15:0] lv);
      @(negedge clk);
      rst_n    = ~rst;
      raw_data = r;
      dst_data = d;
      in_de    = de;
      in_vs    = vs;
      if (lit) lit_q.push_back('{cyc_cnt + 3, lv});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) px(0, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 0, 16'h0);
   endtask

   task automatic vs_pulse();
      px(0, 16'($urandom), 16'($urandom), 1'b0, 1'b1, 0, 16'h0);
      px(0, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 0, 16'h0);
   endtask

   // kind: 0 model only, 1 literal raw, 2 literal dst, 3 split pattern FFFF/0000
   task automatic run_line(input int n, input int kind, input int split);
      logic [15:0] r;
      logic [15:0] d;
      for (int c = 0; c < n; c++) begin
         r = 16'($urandom);
         d = 16'($urandom);
         if (kind == 3) begin r = 16'hFFFF; d = 16'h0000; end
         case (kind)
            1:       px(0, r, d, 1'b1, 1'b0, 1, r);
            2:       px(0, r, d, 1'b1, 1'b0, 1, d);
            3:       px(0, r, d, 1'b1, 1'b0, 1, (c < split) ? 16'hFFFF : 16'h0000);
            default: px(0, r, d, 1'b1, 1'b0, 0, 16'h0);
         endcase
      end
      idle(2);
   endtask

   initial begin
      rst_n = 1'b0; raw_data = 16'h0; dst_data = 16'h0; in_de = 1'b0; in_vs = 1'b0;
      cfg_mode = 2'd0; cfg_alpha = 5'd0; cfg_split_x = 12'd0;

      // Reset held with random traffic and config
      for (int i = 0; i < 4; i++) begin
         cfg_mode = 2'($urandom); cfg_alpha = 5'($urandom); cfg_split_x = 12'($urandom);
         px(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 0, 16'h0);
      end
      idle(3);

      // No VS yet: reset shadows give raw regardless of cfg
      cfg_mode = 2'd3; cfg_alpha = 5'd16;
      run_line(20, 1, 0);
      cfg_mode = 2'($urandom); cfg_alpha = 5'($urandom);
      run_line(20, 1, 0);

      // Midpoint blend
      cfg_mode = 2'd0; cfg_alpha = 5'd8;
      vs_pulse();
      px(0, 16'hF800, 16'h001F, 1'b1, 1'b0, 1, 16'h780F);
      idle(3);

      // Endpoints and clamp
      cfg_alpha = 5'd0;
      vs_pulse();
      for (int l = 0; l < 20; l++) run_line(50, 1, 0);
      cfg_alpha = 5'd16;
      vs_pulse();
      for (int l = 0; l < 4; l++) run_line(50, 2, 0);
      cfg_alpha = 5'd31;
      vs_pulse();
      for (int l = 0; l < 4; l++) run_line(50, 2, 0);

      // Random frames across all modes
      for (int f = 0; f < 8; f++) begin
         cfg_mode = 2'($urandom); cfg_alpha = 5'($urandom);
         cfg_split_x = 12'($urandom_range(0, 40));
         vs_pulse();
         for (int l = 0; l < 4; l++) begin
            cfg_mode = 2'($urandom); cfg_alpha = 5'($urandom);
            run_line($urandom_range(1, 40), 0, 0);
            idle($urandom_range(0, 3));
         end
      end

      // Split boundaries
      cfg_mode = 2'd1; cfg_split_x = 12'd5;
      vs_pulse();
      for (int l = 0; l < 3; l++) run_line(10, 3, 5);
      cfg_split_x = 12'd0;
      vs_pulse();
      run_line(10, 3, 0);
      cfg_split_x = 12'd100;
      vs_pulse();
      run_line(10, 3, 100);

      // Shadowing: mode change mid-frame waits for next VS
      cfg_mode = 2'd2;
      vs_pulse();
      run_line(10, 1, 0);
      cfg_mode = 2'd3;
      run_line(10, 1, 0);
      run_line(10, 1, 0);
      @(posedge clk); #1;
      chk("line_cnt_after_3", 16'(line_cnt), 16'd3);
      begin
         logic [15:0] r;
         logic [15:0] d;
         r = 16'($urandom); d = 16'($urandom);
         px(0, r, d, 1'b1, 1'b1, 1, r);
         @(posedge clk); #1;
         chk("line_cnt_vs_clear", 16'(line_cnt), 16'd0);
         for (int c = 0; c < 6; c++) begin
            r = 16'($urandom); d = 16'($urandom);
            px(0, r, d, 1'b1, 1'b1, 1, d);
         end
      end
      idle(4);

      // Mid-line reset
      run_line(0, 0, 0);
      for (int c = 0; c < 5; c++) px(0, 16'($urandom), 16'($urandom), 1'b1, 1'b0, 0, 16'h0);
      px(1, 16'($urandom), 16'($urandom), 1'b1, 1'b0, 0, 16'h0);
      @(posedge clk); #1;
      chk("rst_data", blend_data, 16'h0000);
      chk("rst_de", 16'(blend_de), 16'd0);
      chk("rst_line_cnt", 16'(line_cnt), 16'd0);
      run_line(8, 1, 0);
      cfg_mode = 2'd1; cfg_split_x = 12'd3;
      vs_pulse();
      run_line(6, 3, 3);
      idle(6);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
